fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buf.sv | 57 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch constants, the buffered fetch entry type and the PC increment helper.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction
endpackage

// File: rtl/fetch_buf.sv
// Flushable DEPTH-entry FIFO; head visible combinationally, 1-cycle push-to-head.
// A push into a full FIFO is accepted only alongside a pop; flush wins over push.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2 * XLEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push_vld,
  input  logic [W-1:0]                 i_push_dat,
  input  logic                         i_pop_vld,
  output logic [W-1:0]                 o_head_dat,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_full, w_push, w_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_pop      = i_pop_vld & ~o_empty;
  assign w_push     = i_push_vld & (~w_full | w_pop);
  assign o_head_dat = r_mem[r_rd];
  assign o_cnt      = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= bump(r_wr);
      if (w_pop)  r_rd <= bump(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_push_dat;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issue-to-if_valid = rsp latency + 1, redirect-to-request = 1 cycle; issue stalls
// when live in-flight + buffered reaches BUF_DEPTH. Optional FETCH_MISALIGN_TRAP_EN adds fetch_misalign.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_taken,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jal_trgt_pc,
  input  logic [XLEN-1:0] jalr_trgt_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            fetch_misalign,
`endif
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int DW = 8;

  logic            r_active;
  logic [XLEN-1:0] r_pc;
  logic [DW-1:0]   r_discard;
  logic            w_redirect, w_halt, w_room, w_disc_room;
  logic            w_req_fire, w_rsp_keep, w_rsp_drop, w_pop;
  logic [XLEN-1:0] w_target_raw, w_target, w_inf_pc;
  logic            w_inf_empty, w_buf_empty;
  logic [CW-1:0]   w_inf_cnt, w_buf_cnt;
  logic [DW:0]     w_outstanding;
  fetch_entry_t    w_head;

  assign w_redirect   = jalr_en | jal_en | branch_taken;
  assign w_target_raw = jalr_en ? jalr_trgt_pc : jal_trgt_pc;
  assign w_target     = w_target_raw & ~XLEN'(INSTR_BYTES - 1);

  // Discarded responses no longer hold buffer space, so they do not throttle issue.
  assign w_outstanding = {1'b0, r_discard} + (DW+1)'(w_inf_cnt);
  assign w_disc_room   = w_outstanding < {1'b0, {DW{1'b1}}};
  assign w_room        = (OW'(w_inf_cnt) + OW'(w_buf_cnt)) < (OW'(BUF_DEPTH) + OW'(w_pop));

  assign imem_req_valid = r_active & ~w_redirect & ~w_halt & w_room & w_disc_room;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_rsp_keep = imem_rsp_valid & ~w_redirect & (r_discard == '0) & ~w_inf_empty;
  assign w_rsp_drop = imem_rsp_valid & ~w_redirect & (r_discard != '0);

  assign if_valid = ~w_buf_empty & ~w_redirect;
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;
  assign w_pop    = if_valid & if_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_halt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_halt <= 1'b0;
    else if (w_redirect) r_halt <= w_target_raw[1];
  end
  assign w_halt         = r_halt;
  assign fetch_misalign = r_halt;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_pc      <= RESET_PC;
      r_discard <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_redirect)      r_pc <= w_target;
      else if (w_req_fire) r_pc <= next_pc(r_pc);
      if (w_redirect)
        r_discard <= DW'(w_outstanding - (DW+1)'(imem_rsp_valid && (w_outstanding != '0)));
      else if (w_rsp_drop)
        r_discard <= r_discard - 1'b1;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH), .W(XLEN)) u_inflight (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_redirect),
    .i_push_vld (w_req_fire),
    .i_push_dat (r_pc),
    .i_pop_vld  (w_rsp_keep),
    .o_head_dat (w_inf_pc),
    .o_empty    (w_inf_empty),
    .o_cnt      (w_inf_cnt)
  );

  fetch_buf #(.DEPTH(BUF_DEPTH), .W($bits(fetch_entry_t))) u_ibuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_redirect),
    .i_push_vld (w_rsp_keep),
    .i_push_dat ({w_inf_pc, imem_rsp_data}),
    .i_pop_vld  (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_buf_empty),
    .o_cnt      (w_buf_cnt)
  );
endmodule
